// File: rtl/alu_result_fifo_pkg.sv
// Shared ALU constants and buffer state encoding for alu_result_fifo.
package alu_result_fifo_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_DEPTH = 4;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/alu_result_fifo_flag_gen.sv
// Combinational zero/negative/parity flags for one ALU result.
// The parity output exists only when ALU_PARITY_EN is defined.
module alu_flag_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
`ifdef ALU_PARITY_EN
  output logic             par_o,
`endif
  output logic             zero_o,
  output logic             neg_o
);

  assign zero_o = (data_i == '0);
  assign neg_o  = data_i[WIDTH-1];
`ifdef ALU_PARITY_EN
  assign par_o  = ^data_i;
`endif

endmodule

// File: rtl/alu_result_fifo.sv
// Small result buffer between the ALU and its consumer; flags are computed at push
// time and stored per entry. Define ALU_PARITY_EN to add the out_par output.
module alu_result_fifo
  import alu_result_fifo_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = ALU_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_zero,
  output logic                     out_neg,
`ifdef ALU_PARITY_EN
  output logic                     out_par,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LastCount = (AW+1)'(DEPTH - 1);

  fifo_state_e      state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             zero_q [DEPTH];
  logic             neg_q  [DEPTH];
`ifdef ALU_PARITY_EN
  logic             par_q  [DEPTH];
  logic             flag_par;
`endif
  logic             flag_zero, flag_neg;
  logic             push, pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flags (
    .data_i (in_data),
`ifdef ALU_PARITY_EN
    .par_o  (flag_par),
`endif
    .zero_o (flag_zero),
    .neg_o  (flag_neg)
  );

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (push) state_d = ACTIVE;
      ACTIVE: begin
        if (push && !pop && count_q == LastCount)   state_d = FULL;
        else if (pop && !push && count_q == 'd1)    state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ACTIVE;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake outputs are registered from the next state, so in_ready only rises
  // on the first clock edge after reset is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        zero_q[i] <= 1'b0;
        neg_q[i]  <= 1'b0;
`ifdef ALU_PARITY_EN
        par_q[i]  <= 1'b0;
`endif
      end
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      if (push) begin
        data_q[wr_ptr_q] <= in_data;
        zero_q[wr_ptr_q] <= flag_zero;
        neg_q[wr_ptr_q]  <= flag_neg;
`ifdef ALU_PARITY_EN
        par_q[wr_ptr_q]  <= flag_par;
`endif
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign out_data  = data_q[rd_ptr_q];
  assign out_zero  = zero_q[rd_ptr_q];
  assign out_neg   = neg_q[rd_ptr_q];
`ifdef ALU_PARITY_EN
  assign out_par   = par_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_alu_result_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_zero;
  logic             out_neg;
`ifdef ALU_PARITY_EN
  logic             out_par;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mq[$];
  logic       mReady;

  typedef struct {
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    int         cnt;
    logic       rdy;
    logic       vld;
    logic [7:0] data;
    logic       z;
    logic       n;
    logic       p;
  } vec_t;

  vec_t tbl[11];

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
`ifdef ALU_PARITY_EN
    .out_par   (out_par),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the reference queue.
  task automatic checkOutput();
    logic [7:0] h;
    cmp("count", 32'(count), 32'(mq.size()));
    cmp("in_ready", 32'(in_ready), 32'(mReady));
    cmp("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      h = mq[0];
      cmp("out_data", 32'(out_data), 32'(h));
      cmp("out_zero", 32'(out_zero), 32'(h == 8'h00));
      cmp("out_neg", 32'(out_neg), 32'(h[7]));
`ifdef ALU_PARITY_EN
      cmp("out_par", 32'(out_par), 32'(^h));
`endif
    end
  endtask

  // Drive one cycle, advance the model on the edge, check at the falling edge.
  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
    logic doPush, doPop;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    doPush = iv && mReady;
    doPop  = (mq.size() != 0) && ordy;
    if (doPop) void'(mq.pop_front());
    if (doPush) mq.push_back(d);
    mReady = (mq.size() < DEPTH);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    mReady = 1'b0;
    #1;
    cmp("in_ready_before_edge", 32'(in_ready), 32'(0));
    applyStimulus(1'b0, 8'h00, 1'b0);
    cmp("in_ready_after_release", 32'(in_ready), 32'(1));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mReady = 1'b0;

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h00, 1'b0, 1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h01, 1'b0, 2, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h80, 1'b0, 3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'hFF, 1'b0, 4, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h5A, 1'b0, 4, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 3, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    cmp("rst_count", 32'(count), 32'(0));
    cmp("rst_out_valid", 32'(out_valid), 32'(0));
    cmp("rst_in_ready", 32'(in_ready), 32'(0));
    cmp("rst_out_data", 32'(out_data), 32'(0));
    cmp("rst_out_zero", 32'(out_zero), 32'(0));
    cmp("rst_out_neg", 32'(out_neg), 32'(0));
`ifdef ALU_PARITY_EN
    cmp("rst_out_par", 32'(out_par), 32'(0));
`endif
    releaseReset();

    // Single push, then fill past full and drain in order.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      cmp($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      cmp($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      cmp($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        cmp($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].data));
        cmp($sformatf("tbl%0d_zero", i), 32'(out_zero), 32'(tbl[i].z));
        cmp($sformatf("tbl%0d_neg", i), 32'(out_neg), 32'(tbl[i].n));
`ifdef ALU_PARITY_EN
        cmp($sformatf("tbl%0d_par", i), 32'(out_par), 32'(tbl[i].p));
`endif
      end
    end

    // Streaming at count 2 wraps both pointers several times.
    applyStimulus(1'b1, 8'hB0, 1'b0);
    applyStimulus(1'b1, 8'hB1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1);
      cmp("stream_count", 32'(count), 32'(2));
    end
    cmp("stream_head", 32'(out_data), 32'(8'hC8));
    applyStimulus(1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1);

    // Full with push and pop together: only the pop happens.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b1);
    cmp("full_pop_count", 32'(count), 32'(3));
    cmp("full_pop_in_ready", 32'(in_ready), 32'(1));
    cmp("full_pop_head", 32'(out_data), 32'(8'h11));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Asynchronous reset in the middle of traffic discards everything.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0);
    rst_n = 1'b0;
    #1;
    cmp("midrst_out_valid", 32'(out_valid), 32'(0));
    cmp("midrst_count", 32'(count), 32'(0));
    cmp("midrst_in_ready", 32'(in_ready), 32'(0));
    cmp("midrst_out_data", 32'(out_data), 32'(0));
    releaseReset();
    applyStimulus(1'b1, 8'h3C, 1'b0);
    cmp("post_rst_head", 32'(out_data), 32'(8'h3C));
    applyStimulus(1'b0, 8'h00, 1'b1);

    for (int i = 0; i < 400; i++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
